// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
// Sequencer and two-port round-robin arbiter in front of the shared 32x32
// unsigned multiplier. Handles the RISC-V M-extension multiplies (MUL, MULH,
// MULHSU, MULHU). Signed operands become magnitudes on accept, the unsigned
// product is sign-corrected in CALC, and the selected 32-bit half is returned
// to the requesting port.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid[1:0]        per-port request valid (bit i = port i)
//   req_ready[1:0]        per-port accept, one-hot or zero
//   req_a0/req_b0/req_op0 port 0 operands and op code
//   req_a1/req_b1/req_op1 port 1 operands and op code
//   resp_valid[1:0]       per-port response valid, one-hot or zero
//   resp_ready[1:0]       per-port response accept
//   resp_data[31:0]       result for the port flagged in resp_valid
//
// Op codes: 00 MUL (low), 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u)

module mul_share_ctrl #(
    parameter int N_PORTS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req_valid,
    output logic [N_PORTS-1:0] req_ready,
    input  logic [31:0]        req_a0,
    input  logic [31:0]        req_b0,
    input  logic [31:0]        req_a1,
    input  logic [31:0]        req_b1,
    input  logic [1:0]         req_op0,
    input  logic [1:0]         req_op1,
    output logic [N_PORTS-1:0] resp_valid,
    input  logic [N_PORTS-1:0] resp_ready,
    output logic [31:0]        resp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        last;
    logic        id;
    logic [31:0] ma, mb;
    logic        neg;
    logic [1:0]  op;
    logic [63:0] prod;

    // Round-robin grant: a lone requester always wins; on a conflict the port
    // that was not served last time wins.
    logic gnt_any, gnt_id;
    assign gnt_any = |req_valid;
    assign gnt_id  = req_valid[1] & (~req_valid[0] | ~last);

    logic accept, resp_done;
    assign accept    = (state == IDLE) & gnt_any & ~rst;
    assign resp_done = (state == RESP) & resp_ready[id];

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[gnt_id] = 1'b1;
    end

    // Operands of the granted port and their sign handling. MUL only needs the
    // low half, which is identical for signed and unsigned, so it stays unsigned.
    logic [31:0] a_sel, b_sel;
    logic [1:0]  op_sel;
    logic        sa, sb;
    assign a_sel  = gnt_id ? req_a1  : req_a0;
    assign b_sel  = gnt_id ? req_b1  : req_b0;
    assign op_sel = gnt_id ? req_op1 : req_op0;
    assign sa     = a_sel[31] & ((op_sel == 2'b01) | (op_sel == 2'b10));
    assign sb     = b_sel[31] & (op_sel == 2'b01);

    // Shared multiplier datapath. Magnitudes are unsigned, so -2^31 maps to
    // 0x80000000 and needs no special case. The negate sits in the same cycle.
    logic [63:0] mul_p, prod_nxt;
    assign mul_p    = {32'h0, ma} * {32'h0, mb};
    assign prod_nxt = neg ? (64'h0 - mul_p) : mul_p;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:                   state_nxt = RESP;
            RESP:    if (resp_done) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last       <= 1'b1;
            id         <= 1'b0;
            ma         <= '0;
            mb         <= '0;
            neg        <= 1'b0;
            op         <= 2'b00;
            prod       <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            if (accept) begin
                id  <= gnt_id;
                op  <= op_sel;
                ma  <= sa ? (32'h0 - a_sel) : a_sel;
                mb  <= sb ? (32'h0 - b_sel) : b_sel;
                neg <= sa ^ sb;
            end
            if (state == CALC) begin
                prod       <= prod_nxt;
                resp_data  <= (op == 2'b00) ? prod_nxt[31:0] : prod_nxt[63:32];
                resp_valid <= 2'b01 << id;
            end
            if (resp_done) begin
                last       <= id;
                resp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
module tb_mul_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_op0, req_op1;
    logic [1:0]  resp_valid, resp_ready;
    logic [31:0] resp_data;

    int tests = 0;
    int fails = 0;

    mul_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request and collects its response; returns latency in cycles
    // from the accept edge to the first cycle resp_valid is visible.
    task automatic run_op(input bit p, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] d,
                          output int lat, output bit to);
        int n;
        to = 1'b0; lat = 0; d = '0;
        if (p == 1'b0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
        else           begin req_a1 = a; req_b1 = b; req_op1 = op; end
        req_valid  = p ? 2'b10 : 2'b01;
        resp_ready = p ? 2'b10 : 2'b01;
        n = 0;
        @(negedge clk);
        while (!req_ready[p] && n < 20) begin @(negedge clk); n++; end
        if (!req_ready[p]) begin to = 1'b1; req_valid = 2'b00; return; end
        @(posedge clk); #1;
        req_valid = 2'b00;
        n = 0;
        @(negedge clk);
        while (!resp_valid[p] && n < 10) begin @(negedge clk); n++; end
        if (!resp_valid[p]) begin to = 1'b1; return; end
        lat = n + 1;
        d   = resp_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11; resp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_op0 = 2'b00; req_op1 = 2'b00;
        @(negedge clk);
        tests++;
        if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        tests++;
        if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
        tests++;
        if (resp_data !== 32'h0) begin fails++; $display("FAIL reset_resp_data: got %h want 00000000", resp_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL first_conflict_grant: got %b want 01", req_ready); end
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        logic [31:0] d; int lat; bit to;
        run_op(1'b0, 2'b00, 32'd7, 32'hFFFFFFFD, d, lat, to);
        tests++;
        if (to) begin fails++; $display("FAIL mul_basic_timeout: got timeout want response"); end
        tests++;
        if (d !== 32'hFFFFFFEB) begin fails++; $display("FAIL mul_basic_data: got %h want ffffffeb", d); end
        tests++;
        if (lat != 2) begin fails++; $display("FAIL mul_basic_latency: got %0d want 2", lat); end
    endtask

    task automatic test_back_to_back();
        int acc[8];
        int na = 0;
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 2'b00;
        req_valid = 2'b01; resp_ready = 2'b01;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0] && na < 8) begin acc[na] = k; na++; end
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (na < 2) begin fails++; $display("FAIL b2b_accepts: got %0d want >=2", na); end
        else begin
            tests++;
            if (acc[1] - acc[0] != 3) begin fails++; $display("FAIL b2b_interval: got %0d want 3", acc[1] - acc[0]); end
        end
    endtask

    task automatic test_sweep();
        logic [1:0]  ops [7] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
        logic [31:0] va  [7] = '{32'h80000000, 32'h80000000, 32'h80000000,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [7] = '{32'h40000000, 32'h40000000, 32'hC0000000,
                                 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        logic [31:0] d; int lat; bit to;
        for (int i = 0; i < 7; i++) begin
            run_op(1'b1, ops[i], va[i], va[i], d, lat, to);
            tests++;
            if (to || d !== exp[i]) begin
                fails++;
                $display("FAIL sweep_%0d op=%b a=b=%h: got %h (timeout=%0d) want %h", i, ops[i], va[i], d, to, exp[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int g[8], rp[8];
        int ng = 0, nr = 0, viol = 0;
        rst = 1'b1;
        req_a0 = 32'd3; req_b0 = 32'd5; req_op0 = 2'b00;
        req_a1 = 32'd3; req_b1 = 32'd5; req_op1 = 2'b00;
        req_valid = 2'b11; resp_ready = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && resp_valid != 2'b00) viol++;
            if (req_ready != 2'b00 && ng < 8) begin g[ng] = int'(req_ready[1]); ng++; end
            if (resp_valid != 2'b00 && nr < 8) begin
                rp[nr] = int'(resp_valid[1]); nr++;
                tests++;
                if (resp_data !== 32'h0000000F) begin fails++; $display("FAIL rr_data: got %h want 0000000f", resp_data); end
            end
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (viol != 0) begin fails++; $display("FAIL rr_ready_and_resp_overlap: got %0d cycles want 0", viol); end
        tests++;
        if (ng < 4 || nr < 4) begin
            fails++; $display("FAIL rr_counts: got grants=%0d resps=%0d want >=4 each", ng, nr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (g[i] != i % 2) begin fails++; $display("FAIL rr_grant_%0d: got port %0d want port %0d", i, g[i], i % 2); end
                tests++;
                if (rp[i] != i % 2) begin fails++; $display("FAIL rr_resp_port_%0d: got port %0d want port %0d", i, rp[i], i % 2); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        req_a0 = 32'hFFFFFFFF; req_b0 = 32'd2; req_op0 = 2'b11;
        req_valid = 2'b01; resp_ready = 2'b00;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        // Port 1 requests and is "ready" during the stall; both must be ignored.
        req_valid = 2'b10; resp_ready = 2'b10;
        n = 0;
        @(negedge clk);
        while (!resp_valid[0] && n < 10) begin @(negedge clk); n++; end
        tests++;
        if (!resp_valid[0]) begin fails++; $display("FAIL bp_no_response: got %b want 01", resp_valid); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (resp_valid !== 2'b01) begin fails++; $display("FAIL bp_valid_%0d: got %b want 01", k, resp_valid); end
            tests++;
            if (resp_data !== 32'h00000001) begin fails++; $display("FAIL bp_data_%0d: got %h want 00000001", k, resp_data); end
            tests++;
            if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_req_ready_%0d: got %b want 00", k, req_ready); end
        end
        req_valid = 2'b00; resp_ready = 2'b01;
        @(negedge clk);
        tests++;
        if (resp_valid !== 2'b00) begin fails++; $display("FAIL bp_release: got %b want 00", resp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int lat; bit to;
        int n = 0, seen = 0;
        req_a0 = 32'd9; req_b0 = 32'd9; req_op0 = 2'b00;
        req_valid = 2'b01; resp_ready = 2'b01;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        tests++;
        if (resp_valid !== 2'b00) begin fails++; $display("FAIL midrst_resp_valid: got %b want 00", resp_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL midrst_stale_resp: got %0d cycles want 0", seen); end
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL midrst_grant: got %b want 01", req_ready); end
        req_valid = 2'b00;
        run_op(1'b0, 2'b00, 32'd2, 32'd2, d, lat, to);
        tests++;
        if (to || d !== 32'h00000004) begin fails++; $display("FAIL midrst_data: got %h (timeout=%0d) want 00000004", d, to); end
        tests++;
        if (lat != 2) begin fails++; $display("FAIL midrst_latency: got %0d want 2", lat); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_back_to_back();
        test_sweep();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Sequencer and two-port arbiter for the shared combinational 32x32 unsigned Wallace-tree multiplier (`Mul`). It accepts RISC-V M-extension multiply requests (MUL, MULH, MULHSU, MULHU) from two requesters, such as the integer pipeline and a debug or accelerator port. It converts signed operands to magnitudes, drives the shared multiplier, and fixes up the product sign. It returns the selected 32-bit half through a per-port valid/ready response.

## Interface
- `N_PORTS`, 2: number of requesters; fixed at 2, not generic.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-port request valid; bit i = port i.
- `req_ready`  out  2  per-port accept; at most one bit high.
- `req_a0`, `req_b0`  in  32 each  port 0 operands rs1, rs2.
- `req_a1`, `req_b1`  in  32 each  port 1 operands.
- `req_op0`, `req_op1`  in  2 each  op codes:
  - 00 MUL: low 32 bits.
  - 01 MULH: signed x signed, high 32.
  - 10 MULHSU: signed a x unsigned b, high 32.
  - 11 MULHU: unsigned x unsigned, high 32.
- `resp_valid`  out  2  per-port response valid; at most one bit high.
- `resp_ready`  in  2  per-port response accept.
- `resp_data`  out  32  result; meaningful only for the port whose `resp_valid` bit is set.

## Operation
- FSM has three states: IDLE, CALC, RESP. Registers:
  - `state`;
  - `last` (1 bit, port granted most recently);
  - `id` (port currently served);
  - operand magnitudes `ma`, `mb` (32 bits each);
  - `neg` (1 bit);
  - `op`;
  - `prod` (64 bits);
  - `resp_data`.
- Arbitration in IDLE is round-robin.
  - With one valid, that port is granted.
  - With both valid, port `!last` is granted.
- `req_ready[i]` is 1 only when state=IDLE and port i is granted. It is combinational from `req_valid`, `state` and `last`, and is forced to 0 while `rst` is high.
- Accept occurs at the edge where `req_valid[i] & req_ready[i]`. On that edge:
  - latch `id`=i and `op`;
  - compute `sa` = a[31] & (op==01 | op==10);
  - compute `sb` = b[31] & (op==01);
  - `ma` = sa ? -a : a;
  - `mb` = sb ? -b : b;
  - `neg` = sa ^ sb;
  - state moves to CALC.
- Magnitude rules:
  - -2^31 has magnitude 0x80000000, which is valid as unsigned.
  - For MUL, sign handling is irrelevant to the low half; MUL takes the unsigned path (sa=sb=0).
- CALC: `ma`, `mb` drive one `Mul` instance.
  - `prod` <= neg ? -(ma*mb) : ma*mb, using 64-bit two's complement; negating 0 gives 0.
  - `resp_data` <= (op==00) ? product[31:0] : product[63:32].
  - State moves to RESP.
- RESP: `resp_valid[id]`=1.
  - `resp_data` and `resp_valid` are held stable until `resp_ready[id]`.
  - On the edge where `resp_ready[id]` is high: `last` <= `id`, `resp_valid` <= 0, state <= IDLE.
  - `resp_ready` on the other port is ignored.
- No new request is accepted in CALC or RESP; `req_ready`=00.
- Reset values:
  - state=IDLE;
  - `last`=1, so port 0 wins the first conflict;
  - `id`=0;
  - `ma`=`mb`=0, `neg`=0, `op`=00, `prod`=0;
  - `resp_valid`=00, `resp_data`=0.
- Reset asserted mid-operation (CALC or RESP) discards the transaction. No response is produced, and the first request after reset is arbitrated normally.

## Timing
- Let accept be edge N.
  - CALC occupies the cycle after N.
  - `resp_valid` rises after edge N+1 and is visible in cycle N+2 (2-cycle latency).
- Minimum initiation interval is 3 cycles per transaction: accept, CALC, and RESP with `resp_ready` already high. The next accept can occur at edge N+3.
- The critical path is the `Mul` tree plus the 64-bit conditional negate, contained within the single CALC cycle.
- `req_ready` and `resp_valid` are never asserted in the same cycle.
- A request deasserted before acceptance is dropped silently; no requirement exists to hold `valid`.

## Test plan
- Port 0, MUL, a=7, b=0xFFFFFFFD, `resp_ready`=1 -> `resp_valid`=01 two cycles after accept, `resp_data`=0xFFFFFFEB; next accept possible 3 cycles after the first.
- Port 1 operand sweep with a=b=0x80000000 -> MULH 0x40000000; MULHU 0x40000000; MULHSU 0xC0000000.
- Port 1 with a=b=0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULHSU 0xFFFFFFFF; MULH 0x00000000; MUL 0x00000001.
- Both ports valid continuously from reset, each with MUL 3x5 -> grants alternate port 0, 1, 0, 1; each response is 0x0000000F on the matching `resp_valid` bit.
- Response backpressure: `resp_ready`=0 for 5 cycles in RESP -> `resp_valid` and `resp_data` stable; `req_ready`=00 throughout; completion occurs on the first cycle `resp_ready` goes high.
- Reset pulse during CALC, then MUL 2x2 on port 0 -> no response for the aborted operation; `resp_valid`=00 immediately; new response is 0x00000004 two cycles after accept.
